// File: rtl/bm_arbiter_if.sv
// Requester-side and block-memory-side signals of the bm_arbiter.
// slave is the arbiter view; master is the environment view.
interface bm_arbiter_if #(
    parameter int REQ_NUM = 3
);
    logic [REQ_NUM-1:0]   req;
    logic [REQ_NUM*5-1:0] req_row;
    logic [REQ_NUM*5-1:0] req_col;
    logic [REQ_NUM*2-1:0] req_func;
    logic [REQ_NUM-1:0]   gnt;
    logic [REQ_NUM-1:0]   done;
    logic                 err;
    logic [3:0]           rdata;
    logic                 bm_enable;
    logic [4:0]           bm_row;
    logic [4:0]           bm_col;
    logic [1:0]           bm_func;
    logic                 bm_ready;
    logic [3:0]           bm_block;

    modport slave (
        input  req, req_row, req_col, req_func, bm_ready, bm_block,
        output gnt, done, err, rdata, bm_enable, bm_row, bm_col, bm_func
    );

    modport master (
        output req, req_row, req_col, req_func, bm_ready, bm_block,
        input  gnt, done, err, rdata, bm_enable, bm_row, bm_col, bm_func
    );
endinterface

// File: rtl/bm_arbiter.sv
// Round-robin arbiter sharing one block-memory port among REQ_NUM requesters.
// IDLE arbitrates and latches the winner, ISSUE strobes bm_enable, WAIT completes or times out.
module bm_arbiter #(
    parameter int REQ_NUM = 3,
    parameter int TIMEOUT = 63
) (
    input  logic        clk_i,
    input  logic        rst_i,
    bm_arbiter_if.slave bus
);
    localparam int PW = $clog2(REQ_NUM);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       sel;
    logic                found;
    logic                finish;
    logic                tmo;
    logic [5:0]          cnt_q, cnt_d;
    logic [REQ_NUM-1:0]  gnt_q, gnt_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          col_q, col_d;
    logic [1:0]          func_q, func_d;
    logic [3:0]          rdata_q, rdata_d;
    logic [4:0]          rows  [REQ_NUM];
    logic [4:0]          cols  [REQ_NUM];
    logic [1:0]          funcs [REQ_NUM];

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= REQ_NUM) j = j - REQ_NUM;
        return j[PW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            rows[i]  = bus.req_row[5*i +: 5];
            cols[i]  = bus.req_col[5*i +: 5];
            funcs[i] = bus.req_func[2*i +: 2];
        end
    end

    // First requesting index at or after ptr, wrapping.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (!found && bus.req[wrap_add(ptr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        row_d   = row_q;
        col_d   = col_q;
        func_d  = func_q;
        rdata_d = rdata_q;
        finish  = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d      = sel;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    row_d      = rows[sel];
                    col_d      = cols[sel];
                    func_d     = funcs[sel];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Counter reads 0 in the first WAIT cycle; abort when it reaches TIMEOUT.
                if (bus.bm_ready) begin
                    finish  = 1'b1;
                    rdata_d = bus.bm_block;
                end else if (cnt_q == 6'(TIMEOUT)) begin
                    finish = 1'b1;
                    tmo    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
                if (finish) begin
                    gnt_d   = '0;
                    ptr_d   = wrap_add(idx_q, 1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            func_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            func_q  <= func_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = {REQ_NUM{finish}} & gnt_q;
    assign bus.err       = tmo;
    assign bus.rdata     = rdata_q;
    assign bus.bm_enable = (state_q == ISSUE);
    assign bus.bm_row    = row_q;
    assign bus.bm_col    = col_q;
    assign bus.bm_func   = func_q;
endmodule
